// File: rtl/pio_pkg.sv
// pio_pkg: shared PIO widths and the encoded-count decode used by OSR, ISR and decoder.
package pio_pkg;
    localparam int DATA_W = 32;
    localparam int COUNT_W = 6;

    function automatic logic [COUNT_W-1:0] cnt_decode(input logic [4:0] c);
        return (c == 5'd0) ? 6'd32 : {1'b0, c};
    endfunction
endpackage

// File: rtl/pio_osr.sv
// pio_osr: PIO output shift register, fed by TX FIFO (PULL/autopull) or MOV,
// emitting 1..32 bits per OUT as a right-justified word.
module pio_osr
    import pio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              penable,
    input  logic              stalled,
    input  logic              shift_right,
    input  logic              autopull,
    input  logic [4:0]        pull_thresh,
    input  logic              out_en,
    input  logic [4:0]        out_count,
    input  logic              pull_en,
    input  logic              pull_block,
    input  logic              pull_ifempty,
    input  logic              mov_en,
    input  logic [DATA_W-1:0] mov_din,
    input  logic [DATA_W-1:0] x_din,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    output logic [DATA_W-1:0] dout,
    output logic [5:0]        shift_count,
    output logic              stall_req
);
    logic [DATA_W-1:0]  shreg_q, shreg_d, src;
    logic [COUNT_W-1:0] count_q, count_d, n, t;
    logic [COUNT_W:0]   sum;
    logic               adv, need;

    assign adv = penable & ~stalled;
    assign n = cnt_decode(out_count);
    assign t = cnt_decode(pull_thresh);
    assign need = autopull & (count_q >= t);
    // OUT consumes straight from the FIFO head when an autopull is due
    assign src = need ? fifo_dout : shreg_q;
    assign sum = (need ? 7'd0 : {1'b0, count_q}) + {1'b0, n};
    assign dout = shift_right ? (src & ~({DATA_W{1'b1}} << n)) : (src >> (6'd32 - n));
    assign shift_count = count_q;

    always_comb begin
        shreg_d = shreg_q;
        count_d = count_q;
        fifo_pop = 1'b0;
        stall_req = 1'b0;
        if (mov_en) begin
            if (adv) begin
                shreg_d = mov_din;
                count_d = '0;
            end
        end else if (pull_en) begin
            if (!(pull_ifempty && count_q < t)) begin
                if (!fifo_empty) begin
                    if (adv) begin
                        shreg_d = fifo_dout;
                        count_d = '0;
                        fifo_pop = 1'b1;
                    end
                end else if (pull_block) begin
                    stall_req = 1'b1;
                end else if (adv) begin
                    shreg_d = x_din;
                    count_d = '0;
                end
            end
        end else if (out_en) begin
            if (need && fifo_empty) begin
                stall_req = 1'b1;
            end else if (adv) begin
                shreg_d = shift_right ? (src >> n) : (src << n);
                count_d = (sum > 7'd32) ? 6'd32 : sum[COUNT_W-1:0];
                fifo_pop = need;
            end
        end else if (need && !fifo_empty && adv) begin
            shreg_d = fifo_dout;
            count_d = '0;
            fifo_pop = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            count_q <= 6'd32;
        end else begin
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_pio_osr.sv
// tb_pio_osr: directed literal checks plus randomized stimulus against an
// arithmetic reference model of the OSR.
module tb_pio_osr;
    logic        clk, reset, penable, stalled, shift_right, autopull;
    logic [4:0]  pull_thresh, out_count;
    logic        out_en, pull_en, pull_block, pull_ifempty, mov_en, fifo_empty;
    logic [31:0] mov_din, x_din, fifo_dout, dout;
    logic        fifo_pop, stall_req;
    logic [5:0]  shift_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_sh, nx_sh;
    int          m_cnt, nx_cnt;

    pio_osr dut (
        .clk(clk), .reset(reset), .penable(penable), .stalled(stalled),
        .shift_right(shift_right), .autopull(autopull), .pull_thresh(pull_thresh),
        .out_en(out_en), .out_count(out_count), .pull_en(pull_en),
        .pull_block(pull_block), .pull_ifempty(pull_ifempty), .mov_en(mov_en),
        .mov_din(mov_din), .x_din(x_din), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .dout(dout),
        .shift_count(shift_count), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shifting done as multiply/divide by powers of two.
    task automatic model_check();
        int n, t, base;
        bit need, adv, e_pop, e_stall, chk_dout;
        longint unsigned s, p;
        logic [31:0] e_dout;
        n = (out_count == 0) ? 32 : int'(out_count);
        t = (pull_thresh == 0) ? 32 : int'(pull_thresh);
        need = autopull && (m_cnt >= t);
        adv = penable && !stalled;
        nx_sh = m_sh;
        nx_cnt = m_cnt;
        e_pop = 0;
        e_stall = 0;
        chk_dout = 0;
        e_dout = 0;
        if (mov_en) begin
            if (adv) begin nx_sh = mov_din; nx_cnt = 0; end
        end else if (pull_en) begin
            if (pull_ifempty && m_cnt < t) begin
                nx_cnt = m_cnt;
            end else if (!fifo_empty) begin
                if (adv) begin nx_sh = fifo_dout; nx_cnt = 0; e_pop = 1; end
            end else if (pull_block) begin
                e_stall = 1;
            end else if (adv) begin
                nx_sh = x_din; nx_cnt = 0;
            end
        end else if (out_en) begin
            if (need && fifo_empty) begin
                e_stall = 1;
            end else begin
                s = need ? longint'(fifo_dout) : longint'(m_sh);
                s = s & 64'hFFFF_FFFF;
                p = 64'd1 << n;
                chk_dout = 1;
                e_dout = shift_right ? 32'(s % p) : 32'(s / (64'd1 << (32 - n)));
                if (adv) begin
                    nx_sh = shift_right ? 32'(s / p) : 32'((s * p) % (64'd1 << 32));
                    base = need ? 0 : m_cnt;
                    nx_cnt = (base + n > 32) ? 32 : base + n;
                    e_pop = need;
                end
            end
        end else if (need && !fifo_empty && adv) begin
            nx_sh = fifo_dout; nx_cnt = 0; e_pop = 1;
        end
        chk("pop", 32'(fifo_pop), 32'(e_pop));
        chk("stall", 32'(stall_req), 32'(e_stall));
        chk("count", 32'(shift_count), m_cnt);
        if (chk_dout) chk("dout", dout, e_dout);
    endtask

    task automatic tick();
        @(posedge clk);
        m_sh = nx_sh;
        m_cnt = nx_cnt;
        #1;
    endtask

    task automatic run();
        @(negedge clk);
        model_check();
    endtask

    task automatic idle();
        penable = 1; stalled = 0; shift_right = 0; autopull = 0; pull_thresh = 0;
        out_en = 0; out_count = 0; pull_en = 0; pull_block = 0; pull_ifempty = 0;
        mov_en = 0; mov_din = 0; x_din = 0; fifo_dout = 0; fifo_empty = 1;
    endtask

    task automatic set_out(input logic [4:0] c, input logic r);
        mov_en = 0; pull_en = 0; out_en = 1; out_count = c; shift_right = r;
    endtask

    task automatic do_mov(input logic [31:0] v);
        idle();
        mov_en = 1; mov_din = v;
        run();
        tick();
        mov_en = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        m_sh = 0; m_cnt = 32;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        run();
        chk("rst_cnt", 32'(shift_count), 32);
        chk("rst_pop", 32'(fifo_pop), 0);
        chk("rst_stall", 32'(stall_req), 0);
        tick();

        do_mov(32'hA5A51234);
        set_out(8, 1); run(); chk("r8_dout", dout, 32'h34); tick();
        chk("r8_cnt", 32'(shift_count), 8);
        set_out(0, 1); run(); chk("r8_rest", dout, 32'h00A5A512); tick();
        do_mov(32'hA5A51234);
        set_out(4, 0); run(); chk("l4_dout", dout, 32'hA); tick();
        chk("l4_cnt", 32'(shift_count), 4);
        set_out(0, 0); run(); chk("l4_rest", dout, 32'h5A512340); tick();

        do_mov(32'hCAFEF00D);
        set_out(0, 1); run(); chk("o32_dout", dout, 32'hCAFEF00D); tick();
        chk("o32_cnt", 32'(shift_count), 32);
        do_mov(32'h0);
        set_out(30, 1); run(); tick();
        set_out(8, 1); run(); tick();
        chk("sat_cnt", 32'(shift_count), 32);

        idle();
        autopull = 1; fifo_dout = 32'hDEADBEEF; fifo_empty = 0;
        set_out(16, 1); run();
        chk("ap_pop", 32'(fifo_pop), 1);
        chk("ap_dout", dout, 32'hBEEF);
        tick();
        chk("ap_cnt", 32'(shift_count), 16);
        autopull = 0; run(); chk("ap_rest", dout, 32'hDEAD); tick();

        autopull = 1; fifo_empty = 1;
        for (int i = 0; i < 3; i++) begin
            run();
            chk("aps_stall", 32'(stall_req), 1);
            chk("aps_pop", 32'(fifo_pop), 0);
            tick();
            chk("aps_cnt", 32'(shift_count), 32);
        end
        fifo_empty = 0;
        run();
        chk("apr_stall", 32'(stall_req), 0);
        chk("apr_pop", 32'(fifo_pop), 1);
        chk("apr_dout", dout, 32'hBEEF);
        tick();
        chk("apr_cnt", 32'(shift_count), 16);
        out_en = 0; pull_thresh = 8; stalled = 1;
        run(); chk("stl_pop", 32'(fifo_pop), 0); tick();
        chk("stl_cnt", 32'(shift_count), 16);

        idle();
        pull_en = 1; pull_block = 1;
        run(); chk("pb_stall", 32'(stall_req), 1); tick();
        pull_block = 0; x_din = 32'h55;
        run(); chk("pnb_pop", 32'(fifo_pop), 0); chk("pnb_stall", 32'(stall_req), 0); tick();
        chk("pnb_cnt", 32'(shift_count), 0);
        set_out(0, 1); run(); chk("pnb_sh", dout, 32'h55); tick();
        do_mov(32'h12345678);
        set_out(8, 1); run(); tick();
        idle();
        pull_en = 1; pull_ifempty = 1; pull_thresh = 16; fifo_empty = 0; fifo_dout = 32'h111;
        run(); chk("pie_pop", 32'(fifo_pop), 0); tick();
        chk("pie_cnt", 32'(shift_count), 8);

        do_mov(32'hFFFF0000);
        set_out(4, 1); run(); tick();
        idle();
        #1 reset = 1;
        #1;
        chk("arst_cnt", 32'(shift_count), 32);
        chk("arst_pop", 32'(fifo_pop), 0);
        m_sh = 0; m_cnt = 32;
        #1 reset = 0;
        set_out(0, 1); run(); chk("arst_sh", dout, 32'h0); tick();

        idle();
        for (int i = 0; i < 3000; i++) begin
            penable = ($urandom_range(0, 9) < 8);
            stalled = ($urandom_range(0, 9) == 0);
            shift_right = 1'($urandom);
            autopull = ($urandom_range(0, 2) != 0);
            pull_thresh = 5'($urandom);
            out_en = ($urandom_range(0, 9) < 6);
            out_count = 5'($urandom);
            pull_en = ($urandom_range(0, 9) == 0);
            pull_block = 1'($urandom);
            pull_ifempty = 1'($urandom);
            mov_en = ($urandom_range(0, 14) == 0);
            mov_din = $urandom;
            x_din = $urandom;
            fifo_dout = $urandom;
            fifo_empty = ($urandom_range(0, 9) < 3);
            run();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
